pkt_mux_lock: RTL and testbench

//  Parametrised N-to-1 packet read multiplexer with packet-atomic port locking and a registered output.

---
 rtl/pkt_mux_lock.sv | 136 +++++++++++++
 tb/tb_pkt_mux_lock.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_mux_lock.sv
// N-to-1 packet read multiplexer: port is chosen at SOP and held until EOP so packets never interleave.
// All outputs are registered (one cycle input-to-output latency), with protocol-error pulses and a packet counter.
module pkt_mux_lock #(
  parameter int unsigned PORT_NUM   = 16,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned SEL_W     = $clog2(PORT_NUM)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [SEL_W-1:0]      i_sel,
  input  logic [PORT_NUM-1:0]   i_rd_sop,
  input  logic [PORT_NUM-1:0]   i_rd_eop,
  input  logic [PORT_NUM-1:0]   i_rd_vld,
  input  logic [DATA_WIDTH-1:0] i_rd_data [PORT_NUM],
  output logic                  o_rd_sop,
  output logic                  o_rd_eop,
  output logic                  o_rd_vld,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_busy,
  output logic [SEL_W-1:0]      o_cur_sel,
  output logic                  o_err_nosop,
  output logic                  o_err_sop,
  output logic [CNT_W-1:0]      o_pkt_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [SEL_W-1:0]      cur_sel_q, cur_sel_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;
  logic                  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_nosop_q, err_nosop_d;
  logic                  err_sop_q, err_sop_d;
  logic [CNT_W-1:0]      pkt_cnt_q, pkt_cnt_d;

  logic [SEL_W-1:0]      port;
  logic                  port_ok;
  logic                  p_vld;
  logic                  p_sop;
  logic                  p_eop;
  logic [DATA_WIDTH-1:0] p_data;

  // Candidate port: the locked one mid-packet, else the requested one if enabled and in range.
  always_comb begin
    port    = (state_q == LOCK) ? cur_sel_q : i_sel;
    port_ok = (state_q == LOCK) || (i_en && (32'(i_sel) < PORT_NUM));
    p_vld   = port_ok && i_rd_vld[port];
    p_sop   = p_vld && i_rd_sop[port];
    p_eop   = p_vld && i_rd_eop[port];
    p_data  = p_vld ? i_rd_data[port] : '0;
  end

  always_comb begin
    state_d     = state_q;
    cur_sel_d   = cur_sel_q;
    sop_d       = 1'b0;
    eop_d       = 1'b0;
    vld_d       = 1'b0;
    data_d      = '0;
    err_nosop_d = 1'b0;
    err_sop_d   = 1'b0;
    pkt_cnt_d   = pkt_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (p_vld && p_sop) begin
          cur_sel_d = i_sel;
          sop_d     = 1'b1;
          eop_d     = p_eop;
          vld_d     = 1'b1;
          data_d    = p_data;
          if (p_eop) pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
          else       state_d   = LOCK;
        end else if (p_vld) begin
          err_nosop_d = 1'b1;
        end
      end
      LOCK: begin
        // A stray SOP inside a packet is forwarded as a plain beat and flagged.
        if (p_vld) begin
          vld_d     = 1'b1;
          eop_d     = p_eop;
          data_d    = p_data;
          err_sop_d = p_sop;
          if (p_eop) begin
            state_d   = IDLE;
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cur_sel_q   <= '0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      vld_q       <= 1'b0;
      data_q      <= '0;
      err_nosop_q <= 1'b0;
      err_sop_q   <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_sel_q   <= cur_sel_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      vld_q       <= vld_d;
      data_q      <= data_d;
      err_nosop_q <= err_nosop_d;
      err_sop_q   <= err_sop_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign o_rd_sop    = sop_q;
  assign o_rd_eop    = eop_q;
  assign o_rd_vld    = vld_q;
  assign o_rd_data   = data_q;
  assign o_busy      = (state_q == LOCK);
  assign o_cur_sel   = cur_sel_q;
  assign o_err_nosop = err_nosop_q;
  assign o_err_sop   = err_sop_q;
  assign o_pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_pkt_mux_lock.sv
// Bench for pkt_mux_lock: directed scenarios with literal expectations plus randomized traffic,
// all checked every cycle against a packet-level reference model.
module tb_pkt_mux_lock;

  localparam int unsigned PORT_NUM   = 12;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned SEL_W      = $clog2(PORT_NUM);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  en;
  logic [SEL_W-1:0]      sel;
  logic [PORT_NUM-1:0]   rd_sop, rd_eop, rd_vld;
  logic [DATA_WIDTH-1:0] rd_data [PORT_NUM];
  logic                  o_rd_sop, o_rd_eop, o_rd_vld, o_busy, o_err_nosop, o_err_sop;
  logic [DATA_WIDTH-1:0] o_rd_data;
  logic [SEL_W-1:0]      o_cur_sel;
  logic [CNT_W-1:0]      o_pkt_cnt;

  int n_checks = 0;
  int n_err    = 0;

  pkt_mux_lock #(
    .PORT_NUM  (PORT_NUM),
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_W     (CNT_W)
  ) u_dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_sel      (sel),
    .i_rd_sop   (rd_sop),
    .i_rd_eop   (rd_eop),
    .i_rd_vld   (rd_vld),
    .i_rd_data  (rd_data),
    .o_rd_sop   (o_rd_sop),
    .o_rd_eop   (o_rd_eop),
    .o_rd_vld   (o_rd_vld),
    .o_rd_data  (o_rd_data),
    .o_busy     (o_busy),
    .o_cur_sel  (o_cur_sel),
    .o_err_nosop(o_err_nosop),
    .o_err_sop  (o_err_sop),
    .o_pkt_cnt  (o_pkt_cnt)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endfunction

  // Reference model: "in a packet or not", owner port, packet count; expected outputs per edge.
  bit       m_ready = 1'b0;
  bit       in_pkt;
  int       m_sel, m_cnt;
  bit       e_vld, e_sop, e_eop, e_nosop, e_errsop;
  logic [DATA_WIDTH-1:0] e_data;

  always @(posedge clk) begin
    e_vld = 0; e_sop = 0; e_eop = 0; e_nosop = 0; e_errsop = 0; e_data = '0;
    if (rst) begin
      in_pkt = 0; m_sel = 0; m_cnt = 0; m_ready = 1;
    end else if (!in_pkt) begin
      if (en && int'(sel) < int'(PORT_NUM) && rd_vld[sel]) begin
        if (rd_sop[sel]) begin
          m_sel = int'(sel);
          e_vld = 1; e_sop = 1; e_eop = rd_eop[sel]; e_data = rd_data[sel];
          if (rd_eop[sel]) m_cnt = (m_cnt + 1) % (1 << CNT_W);
          else             in_pkt = 1;
        end else begin
          e_nosop = 1;
        end
      end
    end else if (rd_vld[m_sel]) begin
      e_vld = 1; e_eop = rd_eop[m_sel]; e_data = rd_data[m_sel]; e_errsop = rd_sop[m_sel];
      if (rd_eop[m_sel]) begin
        in_pkt = 0;
        m_cnt  = (m_cnt + 1) % (1 << CNT_W);
      end
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk("rd_vld",    64'(o_rd_vld),    64'(e_vld));
      chk("rd_sop",    64'(o_rd_sop),    64'(e_sop));
      chk("rd_eop",    64'(o_rd_eop),    64'(e_eop));
      chk("rd_data",   64'(o_rd_data),   64'(e_data));
      chk("busy",      64'(o_busy),      64'(in_pkt));
      chk("cur_sel",   64'(o_cur_sel),   64'(m_sel));
      chk("err_nosop", 64'(o_err_nosop), 64'(e_nosop));
      chk("err_sop",   64'(o_err_sop),   64'(e_errsop));
      chk("pkt_cnt",   64'(o_pkt_cnt),   64'(m_cnt));
    end
  end

  task automatic clr();
    rd_vld = '0; rd_sop = '0; rd_eop = '0;
    for (int i = 0; i < int'(PORT_NUM); i++) rd_data[i] = '0;
  endtask

  task automatic put(int p, bit s, bit e, logic [DATA_WIDTH-1:0] d);
    rd_vld[p] = 1'b1; rd_sop[p] = s; rd_eop[p] = e; rd_data[p] = d;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int busy_cycles;
    rst = 1'b1; en = 1'b0; sel = '0;
    clr();

    // Reset with port 2 active
    en = 1'b1; sel = SEL_W'(2);
    for (int i = 0; i < 3; i++) begin
      clr(); put(2, 1, i == 2, DATA_WIDTH'(32'h200 + i));
      tick();
      chk("rst_vld", 64'(o_rd_vld), 64'd0);
      chk("rst_cnt", 64'(o_pkt_cnt), 64'd0);
      chk("rst_sel", 64'(o_cur_sel), 64'd0);
    end
    clr(); rst = 1'b0; tick();

    // Single 4-beat packet from port 5
    sel = SEL_W'(5); en = 1'b1; busy_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      clr(); put(5, i == 0, i == 3, DATA_WIDTH'(32'hD0 + i));
      tick();
      chk("t2_data", 64'(o_rd_data), 64'(32'hD0 + i));
      chk("t2_sop",  64'(o_rd_sop),  64'(i == 0));
      chk("t2_eop",  64'(o_rd_eop),  64'(i == 3));
      if (o_busy) busy_cycles++;
    end
    chk("t2_busy_cycles", 64'(busy_cycles), 64'd3);
    chk("t2_cnt", 64'(o_pkt_cnt), 64'd1);
    clr(); tick();

    // Select change mid-packet is ignored; port 7 noise never leaks in
    sel = SEL_W'(3); en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin sel = SEL_W'(7); en = 1'b0; end
      clr(); put(3, i == 0, i == 5, DATA_WIDTH'(32'h3000 + i)); put(7, 1, 1, 32'h7777);
      tick();
      chk("t3_data", 64'(o_rd_data), 64'(32'h3000 + i));
    end
    for (int i = 0; i < 2; i++) begin
      clr(); put(7, 1, 1, 32'h7777); tick();
      chk("t3_dis_vld", 64'(o_rd_vld), 64'd0);
    end
    en = 1'b1; clr(); put(7, 1, 1, 32'h7777); tick();
    chk("t3_p7_sel",  64'(o_cur_sel), 64'd7);
    chk("t3_p7_data", 64'(o_rd_data), 64'h7777);

    // Protocol errors
    sel = SEL_W'(1);
    clr(); put(1, 0, 0, 32'hBAD); tick();
    chk("t4_nosop", 64'(o_err_nosop), 64'd1);
    chk("t4_drop",  64'(o_rd_vld),    64'd0);
    clr(); put(1, 1, 0, 32'h11); tick();
    chk("t4_nosop_pulse", 64'(o_err_nosop), 64'd0);
    clr(); put(1, 1, 0, 32'h12); tick();
    chk("t4_errsop", 64'(o_err_sop), 64'd1);
    chk("t4_sop0",   64'(o_rd_sop),  64'd0);
    clr(); put(1, 0, 1, 32'h13); tick();
    chk("t4_errsop_pulse", 64'(o_err_sop), 64'd0);

    // Back-to-back single-beat packets, then a long packet with bubbles
    sel = SEL_W'(0);
    for (int i = 0; i < 8; i++) begin
      clr(); put(0, 1, 1, DATA_WIDTH'(32'hA0 + i)); tick();
      chk("t5_b2b_vld", 64'(o_rd_vld), 64'd1);
    end
    sel = SEL_W'(4);
    for (int i = 0; i < 8; i++) begin
      clr();
      if (i % 2 == 0) put(4, i == 0, i == 6, DATA_WIDTH'(32'h4400 + i));
      else            put(4, 1, 1, 32'hFFFF);
      if (i % 2 == 1) rd_vld[4] = 1'b0;
      tick();
      if (i % 2 == 1) chk("t5_bubble_data", 64'(o_rd_data), 64'd0);
    end
    clr(); tick();

    // Counter wrap and out-of-range select
    rst = 1'b1; tick(); rst = 1'b0;
    sel = SEL_W'(6);
    for (int i = 0; i < 17; i++) begin
      clr(); put(6, 1, 1, DATA_WIDTH'(i)); tick();
    end
    chk("t6_wrap", 64'(o_pkt_cnt), 64'd1);
    sel = SEL_W'(13);
    for (int i = 0; i < 3; i++) begin
      clr();
      for (int p = 0; p < int'(PORT_NUM); p++) put(p, 1, i == 2, 32'hEE);
      tick();
      chk("t6_oor_vld", 64'(o_rd_vld),    64'd0);
      chk("t6_oor_err", 64'(o_err_nosop), 64'd0);
    end

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 4) == 0) sel = SEL_W'($urandom_range(0, (1 << SEL_W) - 1));
      for (int p = 0; p < int'(PORT_NUM); p++) begin
        rd_vld[p]  = ($urandom_range(0, 9) < 7);
        rd_sop[p]  = ($urandom_range(0, 9) < 3);
        rd_eop[p]  = ($urandom_range(0, 9) < 3);
        rd_data[p] = DATA_WIDTH'($urandom);
      end
      tick();
    end
    rst = 1'b0; clr(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
